// File: rtl/pcie_s10_tx_credit_arb.sv
// Credit-aware round-robin owner of the S10 tx_st port for P/NP/CPL sources.
// Grant one cycle after an eligible request; held until the eop beat, reissued no earlier than eop+2.
module pcie_s10_tx_credit_arb #(
  parameter int HDR_CDT_WIDTH  = 8,
  parameter int DATA_CDT_WIDTH = 12,
  parameter int LEN_WIDTH      = 11,
  parameter int CPL_INFINITE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        link_up,
  input  logic [2:0]                  req,
  input  logic [3*LEN_WIDTH-1:0]      req_len,
  output logic [2:0]                  grant,
  output logic                        busy,
  input  logic [HDR_CDT_WIDTH-1:0]    tx_ph_cdts,
  input  logic [HDR_CDT_WIDTH-1:0]    tx_nph_cdts,
  input  logic [HDR_CDT_WIDTH-1:0]    tx_cplh_cdts,
  input  logic [DATA_CDT_WIDTH-1:0]   tx_pd_cdts,
  input  logic [DATA_CDT_WIDTH-1:0]   tx_npd_cdts,
  input  logic [DATA_CDT_WIDTH-1:0]   tx_cpld_cdts,
  input  logic                        tx_hdr_cdts_consumed,
  input  logic                        tx_data_cdts_consumed,
  input  logic [1:0]                  tx_cdts_type,
  input  logic                        tx_cdts_data_value,
  input  logic                        tx_st_valid,
  input  logic                        tx_st_ready,
  input  logic                        tx_st_sop,
  input  logic                        tx_st_eop,
  output logic [2:0]                  stall_credit
);

  localparam int HW = HDR_CDT_WIDTH + 1;
  localparam int DW = DATA_CDT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOP, XFER} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_sel;
  logic [1:0]      r_last;
  logic [2:0]      r_stall;
  logic [HW-1:0]   r_if_h [3];
  logic [DW-1:0]   r_if_d [3];

  logic            w_clr;
  logic            w_beat;
  logic            w_gnt_evt;
  logic [HW-1:0]   w_cdt_h [3];
  logic [DW-1:0]   w_cdt_d [3];
  logic [HW-1:0]   w_avail_h [3];
  logic [DW-1:0]   w_avail_d [3];
  logic [DW-1:0]   w_need_d [3];
  logic [LEN_WIDTH:0] w_len_rnd [3];
  logic [2:0]      w_elig;
  logic [2:0]      w_pick;
  logic [1:0]      w_pick_idx;
  logic            w_found;
  logic [2:0]      w_cand;
  logic [HW-1:0]   w_h_sum [3];
  logic [DW-1:0]   w_d_sum [3];
  logic [HW-1:0]   w_h_dec [3];
  logic [DW-1:0]   w_d_dec [3];
  logic [HW-1:0]   w_h_nxt [3];
  logic [DW-1:0]   w_d_nxt [3];

  // Link loss behaves exactly like reset, even in the middle of a TLP.
  assign w_clr  = rst | ~link_up;
  assign w_beat = tx_st_valid & tx_st_ready;

  assign w_cdt_h[0] = HW'(tx_ph_cdts);
  assign w_cdt_h[1] = HW'(tx_nph_cdts);
  assign w_cdt_h[2] = HW'(tx_cplh_cdts);
  assign w_cdt_d[0] = DW'(tx_pd_cdts);
  assign w_cdt_d[1] = DW'(tx_npd_cdts);
  assign w_cdt_d[2] = DW'(tx_cpld_cdts);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_len_rnd[i] = {1'b0, req_len[i*LEN_WIDTH +: LEN_WIDTH]} + (LEN_WIDTH+1)'(3);
      w_need_d[i]  = DW'(w_len_rnd[i] >> 2);
      w_avail_h[i] = (w_cdt_h[i] > r_if_h[i]) ? (w_cdt_h[i] - r_if_h[i]) : '0;
      w_avail_d[i] = (w_cdt_d[i] > r_if_d[i]) ? (w_cdt_d[i] - r_if_d[i]) : '0;
      w_elig[i]    = req[i] & (w_avail_h[i] != '0) & (w_avail_d[i] >= w_need_d[i]);
    end
    if (CPL_INFINITE != 0) w_elig[2] = req[2];
  end

  // Round-robin search starts at the class after the last one granted.
  always_comb begin
    w_pick     = '0;
    w_pick_idx = r_last;
    w_found    = 1'b0;
    w_cand     = '0;
    for (int k = 1; k <= 3; k++) begin
      w_cand = {1'b0, r_last} + 3'(k);
      if (w_cand >= 3'd3) w_cand = w_cand - 3'd3;
      if (!w_found && w_elig[w_cand[1:0]]) begin
        w_found    = 1'b1;
        w_pick_idx = w_cand[1:0];
        w_pick     = 3'b001 << w_cand[1:0];
      end
    end
  end

  assign w_gnt_evt = (r_state == IDLE) & w_found;

  // In-flight accounting: grant adds, consume strobes subtract, net result floors at zero.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_h_sum[i] = r_if_h[i] + ((w_gnt_evt && w_pick[i]) ? HW'(1) : HW'(0));
      w_d_sum[i] = r_if_d[i] + ((w_gnt_evt && w_pick[i]) ? w_need_d[i] : DW'(0));
      w_h_dec[i] = (tx_hdr_cdts_consumed && tx_cdts_type == 2'(i)) ? HW'(1) : HW'(0);
      w_d_dec[i] = (tx_data_cdts_consumed && tx_cdts_type == 2'(i)) ?
                   (tx_cdts_data_value ? DW'(2) : DW'(1)) : DW'(0);
      w_h_nxt[i] = (w_h_sum[i] > w_h_dec[i]) ? (w_h_sum[i] - w_h_dec[i]) : '0;
      w_d_nxt[i] = (w_d_sum[i] > w_d_dec[i]) ? (w_d_sum[i] - w_d_dec[i]) : '0;
    end
    if (CPL_INFINITE != 0) begin
      w_h_nxt[2] = '0;
      w_d_nxt[2] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      for (int i = 0; i < 3; i++) begin
        r_if_h[i] <= '0;
        r_if_d[i] <= '0;
      end
      r_sel   <= '0;
      r_last  <= 2'd2;
      r_stall <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_if_h[i] <= w_h_nxt[i];
        r_if_d[i] <= w_d_nxt[i];
      end
      if (w_gnt_evt) begin
        r_sel  <= w_pick;
        r_last <= w_pick_idx;
      end
      r_stall <= (r_state == IDLE) ? (req & ~w_elig) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_found) w_state_nxt = WAIT_SOP;
      WAIT_SOP: if (w_beat && tx_st_sop) w_state_nxt = tx_st_eop ? IDLE : XFER;
      XFER:     if (w_beat && tx_st_eop) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant        = (r_state != IDLE) ? r_sel : 3'b000;
    busy         = (r_state != IDLE);
    stall_credit = r_stall;
  end

endmodule

// File: tb/tb_pcie_s10_tx_credit_arb.sv
// Scoreboarded bench for pcie_s10_tx_credit_arb: expected grants queued at stimulus time,
// popped when a new grant appears on the DUT output.
module tb_pcie_s10_tx_credit_arb;

  logic        clk = 1'b0;
  logic        rst, link_up;
  logic [2:0]  req;
  logic [32:0] req_len;
  logic [2:0]  grant;
  logic        busy;
  logic [7:0]  tx_ph_cdts, tx_nph_cdts, tx_cplh_cdts;
  logic [11:0] tx_pd_cdts, tx_npd_cdts, tx_cpld_cdts;
  logic        tx_hdr_cdts_consumed, tx_data_cdts_consumed;
  logic [1:0]  tx_cdts_type;
  logic        tx_cdts_data_value;
  logic        tx_st_valid, tx_st_ready, tx_st_sop, tx_st_eop;
  logic [2:0]  stall_credit;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  prev_grant = 3'b000;

  always #5 clk = ~clk;

  pcie_s10_tx_credit_arb dut (
    .clk(clk), .rst(rst), .link_up(link_up), .req(req), .req_len(req_len),
    .grant(grant), .busy(busy),
    .tx_ph_cdts(tx_ph_cdts), .tx_nph_cdts(tx_nph_cdts), .tx_cplh_cdts(tx_cplh_cdts),
    .tx_pd_cdts(tx_pd_cdts), .tx_npd_cdts(tx_npd_cdts), .tx_cpld_cdts(tx_cpld_cdts),
    .tx_hdr_cdts_consumed(tx_hdr_cdts_consumed), .tx_data_cdts_consumed(tx_data_cdts_consumed),
    .tx_cdts_type(tx_cdts_type), .tx_cdts_data_value(tx_cdts_data_value),
    .tx_st_valid(tx_st_valid), .tx_st_ready(tx_st_ready),
    .tx_st_sop(tx_st_sop), .tx_st_eop(tx_st_eop),
    .stall_credit(stall_credit)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // A fresh grant (rising from idle) must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [2:0] e;
    if (grant != 3'b000 && prev_grant == 3'b000) begin
      if (exp_q.size() == 0) chk("unexpected_grant", 32'(grant), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("grant_order", 32'(grant), 32'(e));
      end
    end
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sop, input logic eop);
    tick();
    tx_st_valid = 1'b1; tx_st_ready = 1'b1; tx_st_sop = sop; tx_st_eop = eop;
    tick();
    tx_st_valid = 1'b0; tx_st_ready = 1'b0; tx_st_sop = 1'b0; tx_st_eop = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != 3'b000) return;
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic set_len(input int cls, input logic [10:0] len);
    req_len[cls*11 +: 11] = len;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req = 3'b000;
    tx_hdr_cdts_consumed = 1'b0; tx_data_cdts_consumed = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; link_up = 1'b1; req = '0; req_len = '0;
    tx_ph_cdts = 8'd4; tx_nph_cdts = 8'd4; tx_cplh_cdts = 8'd4;
    tx_pd_cdts = 12'd8; tx_npd_cdts = 12'd8; tx_cpld_cdts = 12'd8;
    tx_hdr_cdts_consumed = 0; tx_data_cdts_consumed = 0;
    tx_cdts_type = 0; tx_cdts_data_value = 0;
    tx_st_valid = 0; tx_st_ready = 0; tx_st_sop = 0; tx_st_eop = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_credit), 32'd0);
    tick();
    rst = 1'b0;

    // Single P TLP, exact latency, then verify in-flight data=4 via a 5-credit request.
    tick();
    set_len(0, 11'd16); req = 3'b001; exp_q.push_back(3'b001);
    @(negedge clk); chk("lat_cycle_n", 32'(grant), 32'd0);
    @(negedge clk); chk("lat_cycle_n1", 32'(grant), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
    req = 3'b000;
    beat(1'b1, 1'b1);
    @(negedge clk); chk("release_after_eop", 32'(grant), 32'd0);
    set_len(0, 11'd17); req = 3'b001;
    tick(); tick(); tick();
    @(negedge clk); chk("inflight_data_blocks", 32'(stall_credit), 32'd1);
    tick();
    tx_pd_cdts = 12'd9; exp_q.push_back(3'b001);
    wait_grant("inflight_data_grant");
    req = 3'b000;
    beat(1'b1, 1'b1);

    // One header credit: second TLP stalls until a header consume.
    do_reset();
    tx_ph_cdts = 8'd1; tx_pd_cdts = 12'd100;
    set_len(0, 11'd4); req = 3'b001; exp_q.push_back(3'b001);
    wait_grant("ph1_first");
    req = 3'b000;
    beat(1'b1, 1'b1);
    req = 3'b001;
    tick(); tick(); tick();
    @(negedge clk);
    chk("ph1_blocked", 32'(grant), 32'd0);
    chk("ph1_stall", 32'(stall_credit), 32'd1);
    tick();
    tx_hdr_cdts_consumed = 1'b1; tx_cdts_type = 2'd0; exp_q.push_back(3'b001);
    tick();
    tx_hdr_cdts_consumed = 1'b0;
    wait_grant("ph1_second");
    req = 3'b000;
    beat(1'b1, 1'b1);

    // Round robin with all three requesting; ownership held until eop.
    do_reset();
    tx_ph_cdts = 8'd200; tx_nph_cdts = 8'd200; tx_cplh_cdts = 8'd200;
    tx_pd_cdts = 12'd200; tx_npd_cdts = 12'd200; tx_cpld_cdts = 12'd200;
    set_len(0, 11'd4); set_len(1, 11'd4); set_len(2, 11'd4);
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    exp_q.push_back(3'b100); exp_q.push_back(3'b001);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant("rr");
      if (k == 3) req = 3'b000;
      beat(1'b0, 1'b0);
      @(negedge clk); chk("rr_hold_no_sop", 32'(busy), 32'd1);
      beat(1'b1, 1'b0);
      @(negedge clk); chk("rr_hold_xfer", 32'(busy), 32'd1);
      beat(1'b0, 1'b1);
      @(negedge clk); chk("rr_release", 32'(grant), 32'd0);
    end

    // NP with zero data credits: reads pass, writes with payload stall.
    do_reset();
    tx_nph_cdts = 8'd10; tx_npd_cdts = 12'd0;
    set_len(1, 11'd0); req = 3'b010; exp_q.push_back(3'b010);
    wait_grant("np_read");
    req = 3'b000;
    beat(1'b1, 1'b1);
    set_len(1, 11'd1); req = 3'b010;
    tick(); tick(); tick();
    @(negedge clk);
    chk("np_len1_blocked", 32'(grant), 32'd0);
    chk("np_len1_stall", 32'(stall_credit), 32'd2);
    req = 3'b000;
    tick();
    @(negedge clk); chk("stall_clears", 32'(stall_credit), 32'd0);

    // Grant and 2-credit consume in the same cycle net to zero change.
    do_reset();
    tx_ph_cdts = 8'd10; tx_pd_cdts = 12'd2;
    set_len(0, 11'd8); req = 3'b001; exp_q.push_back(3'b001);
    wait_grant("net_first");
    req = 3'b000;
    beat(1'b1, 1'b1);
    req = 3'b001; tx_pd_cdts = 12'd4;
    tx_data_cdts_consumed = 1'b1; tx_cdts_type = 2'd0; tx_cdts_data_value = 1'b1;
    exp_q.push_back(3'b001);
    tick();
    tx_data_cdts_consumed = 1'b0;
    wait_grant("net_same_cycle");
    req = 3'b000;
    beat(1'b1, 1'b1);
    set_len(0, 11'd12); req = 3'b001;
    tick(); tick(); tick();
    @(negedge clk); chk("net_need3_stall", 32'(stall_credit), 32'd1);
    tick();
    tx_pd_cdts = 12'd5; exp_q.push_back(3'b001);
    wait_grant("net_need3_grant");
    req = 3'b000;
    beat(1'b1, 1'b1);

    // Over-consume floors the counter at zero.
    do_reset();
    tx_ph_cdts = 8'd10; tx_pd_cdts = 12'd10;
    set_len(0, 11'd4); req = 3'b001; exp_q.push_back(3'b001);
    wait_grant("sat_first");
    req = 3'b000;
    beat(1'b1, 1'b1);
    tx_data_cdts_consumed = 1'b1; tx_cdts_type = 2'd0; tx_cdts_data_value = 1'b1;
    tick();
    tx_data_cdts_consumed = 1'b0;
    tx_pd_cdts = 12'd1; req = 3'b001; exp_q.push_back(3'b001);
    wait_grant("sat_no_wrap");
    req = 3'b000;
    beat(1'b1, 1'b1);

    // Link loss mid-TLP, then infinite completion credits.
    do_reset();
    tx_ph_cdts = 8'd1; tx_pd_cdts = 12'd1;
    set_len(0, 11'd4); req = 3'b001; exp_q.push_back(3'b001);
    wait_grant("link_first");
    req = 3'b000;
    beat(1'b1, 1'b0);
    link_up = 1'b0;
    tick();
    link_up = 1'b1;
    @(negedge clk);
    chk("link_down_grant", 32'(grant), 32'd0);
    chk("link_down_busy", 32'(busy), 32'd0);
    tick();
    req = 3'b001; exp_q.push_back(3'b001);
    wait_grant("link_counters_cleared");
    req = 3'b000;
    beat(1'b1, 1'b1);
    tx_cplh_cdts = 8'd0; tx_cpld_cdts = 12'd0;
    set_len(2, 11'd64); req = 3'b100; exp_q.push_back(3'b100);
    wait_grant("cpl_infinite");
    req = 3'b000;
    beat(1'b1, 1'b1);

    tick(); tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_s10_tx_credit_arb.md
Name: pcie_s10_tx_credit_arb

Overview:
- Credit-aware TX scheduler for the single-segment (256-bit) Stratix 10 H-/L-Tile TX streaming interface.
- Arbitrates three TLP sources (posted, non-posted, completion) for exclusive ownership of tx_st.
- Grants a source only when enough header and data credits remain, net of locally tracked in-flight consumption not yet reflected in the hard IP's tx_*_cdts.
- Sits between the application TLP muxes and the PCIe hard IP wrapper; it does not carry TLP data itself.

Parameters:
HDR_CDT_WIDTH, 8, width of header credit inputs
DATA_CDT_WIDTH, 12, width of data credit inputs
LEN_WIDTH, 11, request payload length in DW (0 = no payload, max 1024)
CPL_INFINITE, 1, 1 = completion credits treated as infinite (endpoint mode)

Ports:
clk  in  1  core clock (coreclkout_hip domain)
rst  in  1  synchronous active-high reset
link_up  in  1  hard IP link status
req  in  3  per-class request [0]=P [1]=NP [2]=CPL; level, held until granted
req_len  in  3*LEN_WIDTH  payload DW per class, stable while req high
grant  out  3  one-hot ownership of tx_st
busy  out  1  any grant active
tx_ph_cdts/tx_nph_cdts/tx_cplh_cdts  in  HDR_CDT_WIDTH  hard IP available header credits
tx_pd_cdts/tx_npd_cdts/tx_cpld_cdts  in  DATA_CDT_WIDTH  hard IP available data credits
tx_hdr_cdts_consumed  in  1  hard IP header credit consumed strobe
tx_data_cdts_consumed  in  1  hard IP data credit consumed strobe
tx_cdts_type  in  2  0=P 1=NP 2=CPL 3=ignored
tx_cdts_data_value  in  1  0 = 1 data credit, 1 = 2 data credits
tx_st_valid, tx_st_ready, tx_st_sop, tx_st_eop  in  1 each  observed TX handshake
stall_credit  out  3  per class: req high but blocked by credits (registered)

Behaviour:
- Reset (rst=1): grant=0, busy=0, stall_credit=0, state=IDLE, all in-flight counters=0, RR pointer -> P. link_up=0 has the same effect, including mid-TLP: grant drops the next cycle.
- Credits needed per request: hdr=1; data=(req_len+3)>>2 (0 when req_len=0).
- In-flight counters, one pair per class (hdr HDR_CDT_WIDTH+1 bits, data DATA_CDT_WIDTH+1 bits):
  - On grant: add the needed credits.
  - On consume strobe of matching type: hdr -1; data -1 or -2 per tx_cdts_data_value.
  - Grant and consume in the same cycle apply net.
  - Decrement saturates at 0 and never wraps.
- Available credits = cdts input minus in-flight, clamped at 0.
- Eligible class: req & (avail_hdr>=1) & (avail_data>=needed). With CPL_INFINITE=1, CPL is eligible whenever req=1 and its counters are not updated.
- stall_credit[i] is registered: req[i] & ~eligible[i] while IDLE.
- State machine:
  - IDLE: if any class is eligible, choose round-robin starting after the last granted class (reset order P, NP, CPL). Register one-hot grant and go to WAIT_SOP. Latency: eligible req at cycle N -> grant=1 at cycle N+1.
  - WAIT_SOP: on beat (tx_st_valid&tx_st_ready&tx_st_sop): if eop on the same beat -> IDLE, else -> XFER.
  - XFER: on beat with eop -> IDLE. Beats without sop are ignored in WAIT_SOP.
  - grant/busy stay high through WAIT_SOP and XFER and clear the cycle after the eop beat. Back-to-back grant no earlier than eop+2.
- The RR pointer updates only on grant. Ineligible classes are skipped without losing their turn ordering.

Test Plan:
- Reset, P req len=16, ph=4, pd=8 -> grant=001 one cycle later; in-flight P hdr=1, data=4; single-beat sop&eop -> grant=000 next cycle.
- ph=1, two P TLPs back-to-back, no consume strobe -> second blocked, stall_credit[0]=1; hdr consume type=0 -> second granted.
- All three req held, ample credits -> grants ordered P, NP, CPL, P, ...; each released only after its eop beat.
- npd=0, NP req len=0 (read) -> granted; NP req len=1 -> blocked, stall_credit[1]=1.
- Data consume value=1 on same cycle as P grant needing 2 credits with in-flight=2 -> in-flight stays 2; consume with in-flight=1 and value=1 -> 0, no wrap.
- link_up drops during XFER -> grant=000 next cycle, in-flight counters=0, state IDLE; CPL_INFINITE=1 with cplh=0 -> CPL still granted.
